// File: rtl/snn_image_load_ctrl_if.sv
// Bundle between the JTAG mailbox, the SNN core and the image-load controller.
// Slave modport is the controller's view; master modport is the driving side.
interface snn_image_load_ctrl_if #(
    parameter int unsigned CHUNK_W    = 30,
    parameter int unsigned NUM_CHUNKS = 27,
    parameter int unsigned RESULT_W   = 4
);
    localparam int unsigned IMG_W = CHUNK_W * NUM_CHUNKS;
    localparam int unsigned CNT_W = $clog2(NUM_CHUNKS + 1);

    logic [CHUNK_W-1:0]  iDATA;
    logic                iPROGRESS;
    logic                iFINISH;
    logic                iSNN_DONE;
    logic [RESULT_W-1:0] iSNN_RESULT;
    logic [IMG_W-1:0]    oIMAGE;
    logic                oSNN_START;
    logic [RESULT_W-1:0] oRESULT;
    logic                oRESULT_VALID;
    logic                oBUSY;
    logic [CNT_W-1:0]    oCHUNK_CNT;
    logic [1:0]          oERR;

    modport master (
        output iDATA, iPROGRESS, iFINISH, iSNN_DONE, iSNN_RESULT,
        input  oIMAGE, oSNN_START, oRESULT, oRESULT_VALID, oBUSY, oCHUNK_CNT, oERR
    );

    modport slave (
        input  iDATA, iPROGRESS, iFINISH, iSNN_DONE, iSNN_RESULT,
        output oIMAGE, oSNN_START, oRESULT, oRESULT_VALID, oBUSY, oCHUNK_CNT, oERR
    );
endinterface

// File: rtl/snn_image_load_ctrl.sv
// Assembles JTAG mailbox chunks into the SNN image register, launches the SNN,
// waits for done with a timeout and latches the classification result.
module snn_image_load_ctrl #(
    parameter int unsigned CHUNK_W     = 30,
    parameter int unsigned NUM_CHUNKS  = 27,
    parameter int unsigned RESULT_W    = 4,
    parameter int unsigned TIMEOUT_CYC = 1048576
) (
    input  logic                iCLK,
    input  logic                iRESET,
    snn_image_load_ctrl_if.slave io_bus
);
    localparam int unsigned IMG_W = CHUNK_W * NUM_CHUNKS;
    localparam int unsigned CNT_W = $clog2(NUM_CHUNKS + 1);
    localparam int unsigned TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_OVF     = 2'd1;
    localparam logic [1:0] ERR_SHORT   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_prog_d1, r_prog_d2, r_fin_d1, r_fin_d2;
    logic                w_prog_edge, w_fin_edge;
    logic [IMG_W-1:0]    r_image;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_cap, w_wr_idx;
    logic                w_wr_en;
    logic [1:0]          r_err, w_err_nxt;
    logic                r_start, w_start_nxt;
    logic [RESULT_W-1:0] r_result, w_result_nxt;
    logic                r_rv, w_rv_nxt;
    logic                r_busy;
    logic [TO_W-1:0]     r_to, w_to_nxt;

    // Edges are taken between two registered copies, giving the 2-cycle input latency
    assign w_prog_edge = r_prog_d1 & ~r_prog_d2;
    assign w_fin_edge  = r_fin_d1 & ~r_fin_d2;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_state   <= S_IDLE;
            r_prog_d1 <= 1'b0;
            r_prog_d2 <= 1'b0;
            r_fin_d1  <= 1'b0;
            r_fin_d2  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prog_d1 <= io_bus.iPROGRESS;
            r_prog_d2 <= r_prog_d1;
            r_fin_d1  <= io_bus.iFINISH;
            r_fin_d2  <= r_fin_d1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_cap    = r_cnt;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = r_err;
        w_wr_en      = 1'b0;
        w_wr_idx     = r_cnt;
        w_start_nxt  = 1'b0;
        w_result_nxt = r_result;
        w_rv_nxt     = r_rv;
        w_to_nxt     = r_to;
        unique case (r_state)
            S_IDLE: begin
                if (w_prog_edge) begin
                    w_wr_en     = 1'b1;
                    w_wr_idx    = '0;
                    w_cnt_nxt   = CNT_W'(1);
                    w_err_nxt   = ERR_NONE;
                    w_rv_nxt    = 1'b0;
                    w_state_nxt = S_LOAD;
                end else if (w_fin_edge) begin
                    w_err_nxt = ERR_SHORT;
                end
            end
            S_LOAD: begin
                // Chunk capture is resolved first so FINISH sees the updated count
                if (w_prog_edge) begin
                    if (r_cnt < CNT_W'(NUM_CHUNKS)) begin
                        w_wr_en   = 1'b1;
                        w_cnt_cap = r_cnt + CNT_W'(1);
                    end else begin
                        w_err_nxt = ERR_OVF;
                    end
                end
                w_cnt_nxt = w_cnt_cap;
                if (w_fin_edge) begin
                    if (w_cnt_cap == CNT_W'(NUM_CHUNKS)) begin
                        w_start_nxt = 1'b1;
                        w_to_nxt    = '0;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_err_nxt   = ERR_SHORT;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                if (io_bus.iSNN_DONE) begin
                    w_result_nxt = io_bus.iSNN_RESULT;
                    w_rv_nxt     = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_IDLE;
                end else if (r_to == TO_W'(TIMEOUT_CYC - 1)) begin
                    w_err_nxt   = ERR_TIMEOUT;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_nxt = r_to + TO_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_image  <= '0;
            r_cnt    <= '0;
            r_err    <= ERR_NONE;
            r_start  <= 1'b0;
            r_result <= '0;
            r_rv     <= 1'b0;
            r_busy   <= 1'b0;
            r_to     <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
            r_start  <= w_start_nxt;
            r_result <= w_result_nxt;
            r_rv     <= w_rv_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_to     <= w_to_nxt;
            for (int k = 0; k < NUM_CHUNKS; k++) begin
                if (w_wr_en && (w_wr_idx == CNT_W'(k))) begin
                    r_image[k*CHUNK_W +: CHUNK_W] <= io_bus.iDATA;
                end
            end
        end
    end

    assign io_bus.oIMAGE        = r_image;
    assign io_bus.oSNN_START    = r_start;
    assign io_bus.oRESULT       = r_result;
    assign io_bus.oRESULT_VALID = r_rv;
    assign io_bus.oBUSY         = r_busy;
    assign io_bus.oCHUNK_CNT    = r_cnt;
    assign io_bus.oERR          = r_err;
endmodule

// File: doc/snn_image_load_ctrl.md
Name: snn_image_load_ctrl

Overview:
Controller that sequences image transfer from the JTAG mailbox into the SNN. It captures 30-bit chunks on each PROGRESS rising edge and assembles them into an 810-bit image register. On FINISH it checks the chunk count, launches the SNN with a one-cycle start pulse, waits for done with a timeout, and latches the classification result for readback. It sits between the JTAG mailbox signals (DATA/PROGRESS/FINISH) and the SNN core in the top level, on wCLK120.

Parameters:
CHUNK_W, 30, bits per JTAG chunk
NUM_CHUNKS, 27, chunks per image (image width = CHUNK_W*NUM_CHUNKS = 810)
RESULT_W, 4, width of SNN classification result
TIMEOUT_CYC, 1048576, max cycles in RUN before timeout error

Ports:
iCLK  in  1  system clock (wCLK120)
iRESET  in  1  synchronous, active-high reset
iDATA  in  CHUNK_W  chunk data from JTAG mailbox; valid at PROGRESS rising edge
iPROGRESS  in  1  level; each rising edge = one new chunk
iFINISH  in  1  level; rising edge = image complete, start SNN
oIMAGE  out  CHUNK_W*NUM_CHUNKS  assembled image; chunk k at bits [k*CHUNK_W +: CHUNK_W]
oSNN_START  out  1  one-cycle start pulse to SNN
iSNN_DONE  in  1  SNN completion strobe (sampled in RUN only)
iSNN_RESULT  in  RESULT_W  SNN result, valid with iSNN_DONE
oRESULT  out  RESULT_W  latched result
oRESULT_VALID  out  1  oRESULT holds a fresh result
oBUSY  out  1  high in LOAD or RUN
oCHUNK_CNT  out  5  chunks captured in current image (clog2(NUM_CHUNKS+1))
oERR  out  2  sticky error code: 0 none, 1 overflow, 2 short image, 3 timeout

Behaviour:
- Reset (sync, iRESET=1 at posedge): state IDLE; oIMAGE=0, oCHUNK_CNT=0, oSNN_START=0, oRESULT=0, oRESULT_VALID=0, oERR=0, timeout counter=0; edge-detect registers reset to 0. A reset mid-LOAD or mid-RUN aborts immediately; a pending SNN result is dropped.
- Edge detect: registered copies of iPROGRESS and iFINISH; edge = cur & ~prev. iDATA is sampled in the same cycle the edge is detected. No synchronisers; inputs are in the iCLK domain.
- States: IDLE, LOAD, RUN.
- IDLE:
  - PROGRESS edge: write chunk 0, cnt=1, clear oERR and oRESULT_VALID, go to LOAD.
  - FINISH edge: oERR=2, stay in IDLE.
- LOAD:
  - PROGRESS edge with cnt<NUM_CHUNKS: write chunk at index cnt, cnt+1.
  - PROGRESS edge with cnt==NUM_CHUNKS: discard data, oERR=1, stay in LOAD. Image is not modified.
  - FINISH edge with cnt==NUM_CHUNKS: oSNN_START=1 for exactly the next cycle, go to RUN, clear timeout counter.
  - FINISH edge with cnt<NUM_CHUNKS: oERR=2, cnt=0, go to IDLE. No start pulse.
  - PROGRESS and FINISH edges in the same cycle: capture the chunk first, then evaluate FINISH against the updated count.
  - Unwritten chunks keep their old contents (no clear between images).
- RUN:
  - oIMAGE held stable; PROGRESS and FINISH edges ignored.
  - iSNN_DONE: oRESULT=iSNN_RESULT, oRESULT_VALID=1, cnt=0, go to IDLE.
  - Timeout counter increments every cycle. On reaching TIMEOUT_CYC-1 without done: oERR=3, cnt=0, go to IDLE, oRESULT_VALID stays 0.
  - iSNN_DONE on the timeout cycle: done wins.
  - iSNN_DONE in any state other than RUN is ignored.
- Latency:
  - Chunk visible on oIMAGE 1 cycle after the PROGRESS edge is detected (2 cycles after the iPROGRESS rise).
  - oSNN_START asserts 2 cycles after the iFINISH rise.
  - oRESULT/oRESULT_VALID update 1 cycle after iSNN_DONE.
- oBUSY = (state != IDLE), registered.
- oERR is sticky until the next image start (PROGRESS edge in IDLE) or reset.

Test Plan:
- Nominal load: reset; 27 PROGRESS pulses with iDATA=k+1 (k=0..26); FINISH -> oIMAGE[k*30+:30]==k+1 for all k; oCHUNK_CNT=27 before FINISH; exactly one oSNN_START pulse; iSNN_DONE with result 7 -> oRESULT=7, oRESULT_VALID=1, oBUSY=0, oERR=0.
- Short image: 5 chunks then FINISH -> oERR=2, no oSNN_START, state IDLE, oCHUNK_CNT=0. A following PROGRESS clears oERR to 0.
- Overflow: 28 PROGRESS pulses (28th iDATA=30'h3FFFFFFF) -> oERR=1, chunk 26 unchanged, oCHUNK_CNT=27. FINISH still starts the SNN.
- Simultaneous edges: 26 chunks, then the 27th PROGRESS rises in the same cycle as FINISH -> chunk 26 captured, oSNN_START pulses, oERR=0.
- Timeout with TIMEOUT_CYC=16: full load + FINISH, no done -> oERR=3 after 16 RUN cycles, oRESULT_VALID=0. iSNN_DONE arriving afterwards is ignored.
- Reset mid-RUN: assert iRESET 3 cycles after oSNN_START -> all outputs return to reset values next cycle; a later iSNN_DONE produces no result.
